reg_file_mp: RTL
================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of each register entry.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: address width; depth = 2^ADDR_WIDTH.
REQ-003 SHALL have parameter NUM_READ, default 2, legal 1..4: number of independent read ports.
REQ-004 SHALL have parameter ZERO_REG, default 1: when 1, entry 0 reads as zero and ignores writes.
REQ-005 SHALL have port iClk, input, 1: clock; all state updates on its rising edge.
REQ-006 SHALL have port iRst_n, input, 1: reset, synchronous, active-low; clock iClk.
REQ-007 SHALL have port iAddrRead, input, NUM_READ*ADDR_WIDTH: packed read addresses; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 SHALL have port iEnRead, input, NUM_READ: per-port read enable.
REQ-009 SHALL have port oDataRead, output, NUM_READ*DATA_WIDTH: packed read data; port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have ports iAddrWrite0/iDataWrite0/iEnWrite0, input, ADDR_WIDTH/DATA_WIDTH/1: write port 0.
REQ-011 SHALL have ports iAddrWrite1/iDataWrite1/iEnWrite1, input, ADDR_WIDTH/DATA_WIDTH/1: write port 1.
REQ-012 SHALL have port iClear, input, 1: single-cycle request to zero all entries.
REQ-013 SHALL have port oReady, output, 1: high when the file accepts reads and writes (state READY).

Function
REQ-014 SHALL implement a two-state FSM: CLEAR and READY.
REQ-015 In CLEAR, a counter SHALL walk addresses 0 to 2^ADDR_WIDTH-1, writing zero to one entry per cycle, incrementing by 1.
REQ-016 CLEAR->READY SHALL occur on the edge that writes the last entry; oReady SHALL be high the following cycle; no counter wrap-around.
REQ-017 READY->CLEAR SHALL occur on the edge where iClear=1; counter restarts at 0; oReady low the following cycle.
REQ-018 iClear in CLEAR SHALL be ignored (no counter restart).
REQ-019 In CLEAR, iEnWrite0/1 SHALL be ignored and every read-port output SHALL be zero.
REQ-020 In READY, a write with iEnWriteN=1 SHALL update the addressed entry at the rising edge.
REQ-021 Simultaneous writes to the same address SHALL store iDataWrite1 (port 1 wins); different addresses both stored.
REQ-022 Read latency SHALL be one cycle: address sampled at edge t with iEnRead[i]=1; data valid on oDataRead port i after edge t until next enabled read.
REQ-023 With iEnRead[i]=0 at an edge, read port i SHALL hold its previous output.
REQ-024 Reads SHALL be write-first: a read sampled at the same edge as a write to that address returns the new data (port-1 value on same-address collision).
REQ-025 With ZERO_REG=1, reads of address 0 SHALL return zero and writes to address 0 SHALL be discarded, including any bypass.
REQ-026 With ZERO_REG=0, entry 0 SHALL behave as any other entry.
REQ-027 All NUM_READ ports SHALL be independent; any number may read the same address in one cycle.
REQ-028 A read sampled in the cycle oReady becomes 1 SHALL see all entries zero.

Reset
REQ-029 While iRst_n=0 at an edge: state SHALL become CLEAR, counter 0, all oDataRead 0, oReady 0.
REQ-030 Reset asserted mid-CLEAR SHALL restart the walk at address 0; reset in READY SHALL discard no-longer-valid contents via a full CLEAR.
REQ-031 After iRst_n release, oReady SHALL rise exactly 2^ADDR_WIDTH cycles later.

Verification
REQ-032 Defaults: release reset -> oReady=0 for 32 cycles then 1; read all 32 entries -> all 0x00000000.
REQ-033 Write r5=0xDEADBEEF (port 0), next cycle read r5 on ports 0 and 1 -> both 0xDEADBEEF after one cycle; hold iEnRead=0 -> outputs unchanged.
REQ-034 Same-edge write0 r7=0x11111111, write1 r7=0x22222222, read r7 -> 0x22222222 immediately (bypass) and on later read.
REQ-035 Write r0=0xFFFFFFFF with ZERO_REG=1 -> read r0 = 0 same cycle and later; ZERO_REG=0 build -> 0xFFFFFFFF.
REQ-036 Fill r1..r31 nonzero, pulse iClear -> oReady low 32 cycles, reads 0, writes during CLEAR dropped; afterwards all entries 0.
REQ-037 Assert iRst_n=0 at clear count 10 -> walk restarts; oReady rises 32 cycles after release.

Source files
------------

// File: rtl/reg_file_mp.sv
/******************************************************************************
 * Module   : reg_file_mp
 * Purpose  : Multi-read, dual-write register file with registered write-first
 *            reads and a self-sequenced clear walk on reset or request.
 * Revision : 1.0 - initial release
 ******************************************************************************/
`default_nettype none

module reg_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                             iClk,
  input  logic                             iRst_n,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   iAddrRead,
  input  logic [NUM_READ-1:0]              iEnRead,
  output logic [NUM_READ*DATA_WIDTH-1:0]   oDataRead,
  input  logic [ADDR_WIDTH-1:0]            iAddrWrite0,
  input  logic [DATA_WIDTH-1:0]            iDataWrite0,
  input  logic                             iEnWrite0,
  input  logic [ADDR_WIDTH-1:0]            iAddrWrite1,
  input  logic [DATA_WIDTH-1:0]            iDataWrite1,
  input  logic                             iEnWrite1,
  input  logic                             iClear,
  output logic                             oReady
);

  localparam int                    c_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_LAST  = ADDR_WIDTH'(c_DEPTH - 1);
  localparam bit                    c_ZERO  = (ZERO_REG != 0);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_clrCnt;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_mem [c_DEPTH];

  logic w_accept;
  logic w_we0;
  logic w_we1;

  // The edge that requests a clear is already treated as part of the clear.
  assign w_accept = (r_state == READY) && !iClear;
  assign w_we0    = w_accept && iEnWrite0 && !(c_ZERO && (iAddrWrite0 == '0));
  assign w_we1    = w_accept && iEnWrite1 && !(c_ZERO && (iAddrWrite1 == '0));

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_state  <= CLEAR;
      r_clrCnt <= '0;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          if (r_clrCnt == c_LAST) begin
            r_state <= READY;
            r_ready <= 1'b1;
          end else begin
            r_clrCnt <= r_clrCnt + 1'b1;
          end
        end
        READY: begin
          if (iClear) begin
            r_state  <= CLEAR;
            r_clrCnt <= '0;
            r_ready  <= 1'b0;
          end
        end
        default: begin
          r_state  <= CLEAR;
          r_clrCnt <= '0;
          r_ready  <= 1'b0;
        end
      endcase
    end
  end

  // Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge iClk) begin
    if (iRst_n) begin
      if (r_state == CLEAR) begin
        r_mem[r_clrCnt] <= '0;
      end else begin
        if (w_we0) r_mem[iAddrWrite0] <= iDataWrite0;
        if (w_we1) r_mem[iAddrWrite1] <= iDataWrite1;
      end
    end
  end

  assign oReady = r_ready;

  for (genvar i = 0; i < NUM_READ; i++) begin : g_read
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] r_data;

    assign w_addr = iAddrRead[i*ADDR_WIDTH +: ADDR_WIDTH];

    always_ff @(posedge iClk) begin
      if (!iRst_n) begin
        r_data <= '0;
      end else if (!w_accept) begin
        r_data <= '0;
      end else if (iEnRead[i]) begin
        if (c_ZERO && (w_addr == '0))
          r_data <= '0;
        else if (w_we1 && (w_addr == iAddrWrite1))
          r_data <= iDataWrite1;
        else if (w_we0 && (w_addr == iAddrWrite0))
          r_data <= iDataWrite0;
        else
          r_data <= r_mem[w_addr];
      end
    end

    assign oDataRead[i*DATA_WIDTH +: DATA_WIDTH] = r_data;
  end

endmodule

`default_nettype wire
